// File: rtl/count_seq_pkg.sv
// count_seq_pkg: state encoding and defaults shared by the count_sequencer slice
package count_seq_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam int RCNT_W_DEF = 8;
endpackage

// File: rtl/count_datapath.sv
// count_datapath: count register with load/advance, N+1-bit adder and terminal compare
module count_datapath #(
  parameter int N      = 32,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [N-1:0]      load_val,
  input  logic [N-1:0]      limit,
  input  logic [STEP_W-1:0] step,
  output logic [N-1:0]      count,
  output logic              terminal
);
  logic [N:0] sum;
  // the extra carry bit makes a wrap past all-ones count as reaching the limit
  assign sum      = {1'b0, count} + (N+1)'(step);
  assign terminal = sum >= {1'b0, limit};
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (advance) count <= sum[N-1:0];
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: run controller sequencing config load -> count -> terminal for a loadable counter
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int N      = 32,
  parameter int STEP_W = 8,
  parameter int RCNT_W = RCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [N-1:0]      cfg_seed,
  input  logic [N-1:0]      cfg_limit,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              cfg_reload,
  input  logic              go,
  input  logic              pause,
  input  logic              abort,
  output logic [N-1:0]      count,
  output logic              busy,
  output logic              done,
  output logic [RCNT_W-1:0] reload_cnt
);
  logic [2:0]        state, nxt;
  logic [N-1:0]      seed_r, limit_r;
  logic [STEP_W-1:0] step_r;
  logic              reload_r, take, act, hit, terminal;
  assign cfg_ready = state == ST_IDLE;
  assign busy      = state == ST_RUN || state == ST_HOLD;
  assign take      = cfg_valid && cfg_ready;
  assign act       = state == ST_RUN && !abort && !pause;
  assign hit       = act && terminal;
  count_datapath #(.N(N), .STEP_W(STEP_W)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (take || hit),
    .advance  (act && !terminal),
    .load_val (take ? cfg_seed : reload_r ? seed_r : limit_r),
    .limit    (limit_r),
    .step     (step_r),
    .count    (count),
    .terminal (terminal)
  );
  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE:  nxt = take ? ST_ARMED : ST_IDLE;
      ST_ARMED: nxt = abort ? ST_IDLE : go ? ST_RUN : ST_ARMED;
      ST_RUN:   nxt = abort ? ST_IDLE : pause ? ST_HOLD : (terminal && !reload_r) ? ST_DONE : ST_RUN;
      ST_HOLD:  nxt = abort ? ST_IDLE : pause ? ST_HOLD : ST_RUN;
      default:  nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state      <= ST_IDLE;
      seed_r     <= '0;
      limit_r    <= '0;
      step_r     <= '0;
      reload_r   <= 1'b0;
      done       <= 1'b0;
      reload_cnt <= '0;
    end else begin
      state <= nxt;
      done  <= hit;
      if (take) begin
        seed_r     <= cfg_seed;
        limit_r    <= cfg_limit;
        step_r     <= cfg_step;
        reload_r   <= cfg_reload;
        reload_cnt <= '0;
      end else if (hit && reload_r && reload_cnt != '1)
        reload_cnt <= reload_cnt + RCNT_W'(1);
    end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed checks of count_sequencer with N=8, RCNT_W=2
module tb_count_sequencer;
  logic       clk = 0, rst = 1, cfg_valid = 0, cfg_reload = 0, go = 0, pause = 0, abort = 0;
  logic [7:0] cfg_seed = 0, cfg_limit = 0, cfg_step = 0;
  logic       cfg_ready, busy, done;
  logic [7:0] count;
  logic [1:0] reload_cnt;
  int passed = 0, total = 0;
  bit watch = 0, seen = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (watch && done) seen <= 1'b1;
  count_sequencer #(.N(8), .STEP_W(8), .RCNT_W(2)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_seed(cfg_seed),
    .cfg_limit(cfg_limit), .cfg_step(cfg_step), .cfg_reload(cfg_reload), .go(go), .pause(pause),
    .abort(abort), .count(count), .busy(busy), .done(done), .reload_cnt(reload_cnt)
  );
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic cfg(input int seed, input int limit, input int step, input bit rl);
    cfg_valid = 1; cfg_seed = 8'(seed); cfg_limit = 8'(limit); cfg_step = 8'(step); cfg_reload = rl;
    tick();
    cfg_valid = 0;
  endtask
  task automatic start();
    go = 1;
    tick();
    go = 0;
  endtask
  initial begin
    tick(2);
    rst = 0;
    chk("rst_count", int'(count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rcnt", int'(reload_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    // one-shot 0 -> 10 step 3
    cfg(0, 10, 3, 0);
    chk("t1_armed_ready", int'(cfg_ready), 0);
    start();
    chk("t1_run_busy", int'(busy), 1);
    chk("t1_run_count0", int'(count), 0);
    tick(); chk("t1_c3", int'(count), 3);
    tick(); chk("t1_c6", int'(count), 6);
    tick(); chk("t1_c9", int'(count), 9);
    chk("t1_nodone", int'(done), 0);
    tick(); chk("t1_c10", int'(count), 10);
    chk("t1_done", int'(done), 1);
    chk("t1_busy0", int'(busy), 0);
    tick(); chk("t1_idle_ready", int'(cfg_ready), 1);
    chk("t1_done_clr", int'(done), 0);
    chk("t1_hold10", int'(count), 10);
    // auto-reload 5 -> 8 step 1, reload counter saturates at 3
    cfg(5, 8, 1, 1);
    chk("t2_load", int'(count), 5);
    start();
    for (int k = 1; k <= 5; k++) begin
      tick(); chk("t2_c6", int'(count), 6);
      chk("t2_d0", int'(done), 0);
      tick(); chk("t2_c7", int'(count), 7);
      tick(); chk("t2_c5", int'(count), 5);
      chk("t2_done", int'(done), 1);
      chk("t2_busy", int'(busy), 1);
      chk("t2_rcnt", int'(reload_cnt), k > 3 ? 3 : k);
    end
    abort = 1; tick(); abort = 0;
    chk("t2_abort_ready", int'(cfg_ready), 1);
    chk("t2_abort_count", int'(count), 5);
    chk("t2_abort_rcnt", int'(reload_cnt), 3);
    chk("t2_abort_done", int'(done), 0);
    // overflow guard: 250 + 10 must not wrap
    cfg(250, 255, 10, 0);
    chk("t3_rcnt_clr", int'(reload_cnt), 0);
    start();
    tick(); chk("t3_c255", int'(count), 255);
    chk("t3_done", int'(done), 1);
    tick(); chk("t3_idle", int'(cfg_ready), 1);
    // handshake ignored outside IDLE, accepted in the IDLE cycle after DONE
    cfg(0, 4, 2, 0);
    cfg_valid = 1; cfg_seed = 77;
    chk("t5_armed_ready", int'(cfg_ready), 0);
    start();
    chk("t5_run_ready", int'(cfg_ready), 0);
    tick(); chk("t5_c2", int'(count), 2);
    tick(); chk("t5_c4", int'(count), 4);
    chk("t5_done", int'(done), 1);
    tick(); chk("t5_nocapture", int'(count), 4);
    chk("t5_ready", int'(cfg_ready), 1);
    tick(); cfg_valid = 0;
    chk("t5_newseed", int'(count), 77);
    chk("t5_armed", int'(cfg_ready), 0);
    abort = 1; tick(); abort = 0;
    chk("t5_armed_abort", int'(cfg_ready), 1);
    chk("t5_abort_count", int'(count), 77);
    // pause and abort, done must never pulse
    cfg(0, 100, 1, 0);
    start();
    watch = 1;
    tick(20); chk("t4_c20", int'(count), 20);
    pause = 1;
    tick(); chk("t4_freeze", int'(count), 20);
    chk("t4_busy", int'(busy), 1);
    tick(4); chk("t4_still20", int'(count), 20);
    chk("t4_hold_busy", int'(busy), 1);
    pause = 0;
    tick(); chk("t4_resume", int'(count), 20);
    tick(); chk("t4_c21", int'(count), 21);
    tick(9); chk("t4_c30", int'(count), 30);
    abort = 1; tick(); abort = 0;
    chk("t4_abort_count", int'(count), 30);
    chk("t4_abort_busy", int'(busy), 0);
    chk("t4_abort_ready", int'(cfg_ready), 1);
    tick();
    watch = 0;
    chk("t4_done_never", int'(seen), 0);
    // synchronous reset mid-run
    cfg(0, 100, 1, 0);
    start();
    tick(40); chk("t6_c40", int'(count), 40);
    rst = 1; tick(); rst = 0;
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_ready", int'(cfg_ready), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
